ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter; it sends one command byte (LED set 0xED, reset 0xFF, typematic 0xF3 and so on) from the FPGC to the keyboard on the same PS2_clk/PS2_data pair the existing scan-code receiver listens on. It drives both lines open-drain: it pulls low or releases, never drives high. It performs the inhibit/request-to-send sequence, shifts the frame out on device-generated clocks and checks the device acknowledge. It sits beside the PS/2 receiver behind the MemoryUnit I/O map, and `busy` gates the receiver's `PS2_int`.

---
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. It sends one command byte to the keyboard
// over open-drain PS2_clk/PS2_data: it pulls a line low or releases it.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 2500,
  parameter int unsigned START_TIMEOUT  = 375000,
  parameter int unsigned BIT_TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [18:0] INHIBIT_LAST = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] START_LIMIT  = 19'(START_TIMEOUT);
  localparam logic [18:0] BIT_LIMIT    = 19'(BIT_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_FIRST,
    S_SHIFT,
    S_ACK,
    S_ACK_SAMPLE,
    S_WAIT_IDLE,
    S_DONE,
    S_FAIL
  } state_t;

  state_t      state, state_n;
  logic [9:0]  frame, frame_n;
  logic [3:0]  bitcnt, bitcnt_n;
  logic [18:0] timer;
  logic        clk_s1, clk_s2, clk_prev;
  logic        data_s1, data_s2;
  logic        fall;
  logic        counts_edges;
  logic        clk_oe_n, data_oe_n, busy_n, done_n, error_n;

  // Two-flop synchronizers on both pins plus an edge-detect register on clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // Only device-clocked states restart the timer on a falling edge; this keeps
  // the host's own inhibit pull-down from being seen as device activity.
  assign counts_edges = (state == S_SHIFT) || (state == S_ACK) || (state == S_WAIT_IDLE);

  // Timeout/interval timer, cleared on state changes and device falling edges.
  always_ff @(posedge clk) begin
    if (reset || (state_n != state) || (state == S_IDLE) || (fall && counts_edges)) begin
      timer <= '0;
    end else begin
      timer <= timer + 19'd1;
    end
  end

  // Next-state, frame, bit counter and next output values.
  always_comb begin
    state_n   = state;
    frame_n   = frame;
    bitcnt_n  = bitcnt;
    data_oe_n = ps2_data_oe;
    error_n   = error;

    case (state)
      S_IDLE: begin
        data_oe_n = 1'b0;
        if (start) begin
          frame_n  = {1'b1, ~^tx_data, tx_data};
          bitcnt_n = '0;
          error_n  = 1'b0;
          state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer == INHIBIT_LAST) begin
          data_oe_n = 1'b1;
          state_n   = S_RTS;
        end
      end
      S_RTS: begin
        state_n = S_WAIT_FIRST;
      end
      S_WAIT_FIRST: begin
        // The first device clock already carries data bit 0, so it is placed
        // here rather than on the next falling edge.
        if (fall) begin
          data_oe_n = ~frame[0];
          bitcnt_n  = 4'd1;
          state_n   = S_SHIFT;
        end else if (timer == START_LIMIT) begin
          state_n = S_FAIL;
        end
      end
      S_SHIFT: begin
        if (fall) begin
          data_oe_n = ~frame[bitcnt];
          bitcnt_n  = bitcnt + 4'd1;
          if (bitcnt == 4'd9) begin
            state_n = S_ACK;
          end
        end else if (timer == BIT_LIMIT) begin
          state_n = S_FAIL;
        end
      end
      S_ACK: begin
        data_oe_n = 1'b0;
        if (fall) begin
          state_n = S_ACK_SAMPLE;
        end else if (timer == BIT_LIMIT) begin
          state_n = S_FAIL;
        end
      end
      S_ACK_SAMPLE: begin
        state_n = data_s2 ? S_FAIL : S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (clk_s2 && data_s2) begin
          state_n = S_DONE;
        end else if (timer == BIT_LIMIT) begin
          state_n = S_FAIL;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_FAIL: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    if (state_n == S_FAIL) begin
      error_n   = 1'b1;
      data_oe_n = 1'b0;
    end
    if (state_n == S_DONE) begin
      error_n = 1'b0;
    end
    if (state_n == S_IDLE) begin
      data_oe_n = 1'b0;
    end

    clk_oe_n = (state_n == S_INHIBIT) || (state_n == S_RTS);
    busy_n   = (state_n != S_IDLE);
    done_n   = (state_n == S_DONE) || (state_n == S_FAIL);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      frame       <= '0;
      bitcnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_n;
      frame       <= frame_n;
      bitcnt      <= bitcnt_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      busy        <= busy_n;
      done        <= done_n;
      error       <= error_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned STO = 100;
  localparam int unsigned BTO = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tx_data;
  logic       dev_clk_low  = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, error;

  // Wired-AND bus: a line is low if either side pulls it.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  // 10-unit system clock.
  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .BIT_TIMEOUT   (BTO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_total = 0;

  // Free-running cycle count and count of done pulses.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_total <= done_total + 1;

  logic [9:0] cap;
  int         last_fall;
  int         done_cyc;
  logic       got_err;

  typedef struct {
    logic [7:0] d;
    bit         nack;
    logic [9:0] exp_bits;
    logic       exp_err;
  } vec_t;

  vec_t vecs[4];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference frame: data LSB first, odd parity, stop bit 1.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int   ones = 0;
    logic p;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = ((ones % 2) == 0);
    return {1'b1, p, d};
  endfunction

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Device: waits for request-to-send, then clocks nclk bits at 40 clk/bit,
  // sampling data on rising edges and ACKing on the 11th clock unless nack.
  task automatic dev(input int nclk, input bit nack);
    int n = 0;
    while (!(ps2_clk_in && !ps2_data_in) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("dev_request_seen", 32'(n < 2000), 1);
    repeat (30) @(negedge clk);
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11 && !nack) begin
        dev_data_low = 1'b1;
        @(negedge clk);
      end
      dev_clk_low = 1'b1;
      last_fall   = cyc;
      repeat (20) @(negedge clk);
      if (i <= 10) cap[i-1] = ps2_data_in;
      dev_clk_low = 1'b0;
      repeat (20) @(negedge clk);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic watch(input string name);
    int n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, 32'(done), 1);
    done_cyc = cyc;
    got_err  = error;
    check({name, "_busy_at_done"}, 32'(busy), 1);
    @(negedge clk);
    check({name, "_busy_after"}, 32'(busy), 0);
    check({name, "_oe_after"}, 32'({ps2_clk_oe, ps2_data_oe}), 0);
    check({name, "_done_pulse"}, 32'(done), 0);
  endtask

  task automatic check_inhibit(input string name);
    int n = 0;
    check({name, "_busy_start"}, 32'({busy, ps2_clk_oe, ps2_data_oe}), 32'b110);
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_inhibit_len"}, 32'(n), INH);
    check({name, "_rts"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
    @(negedge clk);
    check({name, "_clk_release"}, 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input bit nack,
                           input bit timing, input logic [9:0] exp_bits, input logic exp_err);
    cap = '0;
    fork
      dev(11, nack);
      begin
        pulse_start(d);
        if (timing) check_inhibit(name);
        watch(name);
      end
    join
    check({name, "_bits"}, 32'(cap), 32'(exp_bits));
    check({name, "_error"}, 32'(got_err), 32'(exp_err));
    check({name, "_error_hold"}, 32'(error), 32'(exp_err));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rel;
    int snap;
    logic [7:0] rd;
    bit rn;

    reset   = 1'b1;
    start   = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({ps2_clk_oe, ps2_data_oe, busy, done, error}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    vecs[0] = '{d: 8'hED, nack: 1'b0, exp_bits: 10'h3ED, exp_err: 1'b0};
    vecs[1] = '{d: 8'hF4, nack: 1'b0, exp_bits: 10'h2F4, exp_err: 1'b0};
    vecs[2] = '{d: 8'h00, nack: 1'b0, exp_bits: 10'h300, exp_err: 1'b0};
    vecs[3] = '{d: 8'hFF, nack: 1'b1, exp_bits: 10'h3FF, exp_err: 1'b1};

    // Device clock activity while idle must be ignored.
    snap = done_total;
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
    end
    check("idle_activity", 32'({busy, ps2_clk_oe, ps2_data_oe}), 0);
    check("idle_no_done", 32'(done_total - snap), 0);

    for (int i = 0; i < 4; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].nack, (i == 0),
                vecs[i].exp_bits, vecs[i].exp_err);
    end

    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom_range(0, 255));
      rn = ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", i), rd, rn, 1'b0, model_frame(rd), rn);
    end

    // Device never clocks: FAIL once the timer reaches START_TIMEOUT.
    pulse_start(8'hED);
    n = 0;
    while (ps2_clk_oe && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("start_to_release", 32'(ps2_clk_oe), 0);
    rel = cyc;
    watch("start_to");
    check("start_to_latency", 32'(done_cyc - rel), STO + 1);
    check("start_to_error", 32'(got_err), 1);

    // Device stops after 4 bits: FAIL BIT_TIMEOUT after the last detected edge
    // (3 cycles pin-to-decision, then one registered cycle).
    fork
      dev(4, 1'b0);
      begin
        pulse_start(8'hF3);
        watch("bit_to");
      end
    join
    check("bit_to_latency", 32'(done_cyc - last_fall), BTO + 4);
    check("bit_to_error", 32'(got_err), 1);

    // Reset in the middle of a frame.
    fork
      dev(5, 1'b0);
      pulse_start(8'hA5);
    join
    check("midframe_busy", 32'(busy), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midframe_reset", 32'({ps2_clk_oe, ps2_data_oe, busy, done, error}), 0);
    repeat (5) @(negedge clk);

    // A start while busy is ignored: one frame with the first byte, one done.
    snap = done_total;
    cap  = '0;
    fork
      dev(11, 1'b0);
      begin
        pulse_start(8'h5A);
        repeat (100) @(negedge clk);
        pulse_start(8'hC3);
        n = 0;
        while (!done && n < 4000) begin
          @(negedge clk);
          n++;
        end
      end
    join
    repeat (300) @(negedge clk);
    check("busy_start_dones", 32'(done_total - snap), 1);
    check("busy_start_bits", 32'(cap), 32'(model_frame(8'h5A)));
    check("busy_start_idle", 32'({busy, error}), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
